// File: rtl/tc_timer.sv
// tc_timer: memory-mapped count-down timer (CTRL/PRESET/COUNT), optional TC_PRESCALE_EN adds PRESCALE at offset 3.
// Reads are combinational, writes land on the clock edge; the bus is never stalled.
module tc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
    parameter int          CNT_W     = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_CNT  = 2'd2;
    localparam logic [1:0] S_INT  = 2'd3;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             ctrl_en;
    logic [1:0]       ctrl_mode;
    logic             ctrl_im;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             irq_flag;

    logic [1:0]  offset;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [31:0] wmask;
    logic [31:0] preset_ext;
    logic [31:0] count_ext;
    logic [31:0] preset_merged;
    logic        reload_mode;
    logic        cnt_done;
    logic        tick;
    logic        expire;
    logic        unused_addr_bits;

    assign offset           = addr[3:2];
    assign hit              = (addr[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl          = hit && we && (offset == OFF_CTRL);
    assign wr_preset        = hit && we && (offset == OFF_PRESET);
    assign unused_addr_bits = ^addr[1:0];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            wmask[8*i +: 8] = {8{byteen[i]}};
        end
    end

    always_comb begin
        preset_ext              = '0;
        preset_ext[CNT_W-1:0]   = preset;
        count_ext               = '0;
        count_ext[CNT_W-1:0]    = count;
    end

    assign preset_merged = (preset_ext & ~wmask) | (wdata & wmask);

    // Modes 1x behave as one-shot; only 01 reloads.
    assign reload_mode = (ctrl_mode == 2'b01);
    assign cnt_done    = (count[CNT_W-1:1] == '0);

`ifdef TC_PRESCALE_EN
    logic [7:0] prescale;
    logic [7:0] pcnt;
    logic       wr_prescale;

    assign wr_prescale = hit && we && (offset == OFF_RSVD);
    assign tick        = (pcnt == 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale <= 8'd0;
            pcnt     <= 8'd0;
        end else begin
            if (wr_prescale && byteen[0]) begin
                prescale <= wdata[7:0];
            end
            // A PRESCALE write restarts the divider with the value just written.
            if (wr_prescale) begin
                pcnt <= byteen[0] ? wdata[7:0] : prescale;
            end else if (state == S_LOAD) begin
                pcnt <= prescale;
            end else if (state == S_CNT && ctrl_en) begin
                pcnt <= tick ? prescale : pcnt - 8'd1;
            end
        end
    end
`else
    assign tick = 1'b1;
`endif

    assign expire = (state == S_CNT) && ctrl_en && tick && cnt_done;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (ctrl_en) state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_CNT;
            S_CNT: begin
                if (!ctrl_en) begin
                    state_nxt = S_IDLE;
                end else if (tick && cnt_done) begin
                    state_nxt = S_INT;
                end
            end
            S_INT:   state_nxt = reload_mode ? S_LOAD : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A CPU write to CTRL always overrides the one-shot auto-clear of EN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_en   <= 1'b0;
            ctrl_mode <= 2'b00;
            ctrl_im   <= 1'b0;
        end else if (wr_ctrl) begin
            if (byteen[0]) begin
                ctrl_en   <= wdata[0];
                ctrl_mode <= wdata[2:1];
                ctrl_im   <= wdata[3];
            end
        end else if (state == S_INT && !reload_mode) begin
            ctrl_en <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= '0;
        end else if (wr_preset) begin
            preset <= preset_merged[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (state == S_LOAD) begin
            count <= preset;
        end else if (state == S_CNT && ctrl_en && tick) begin
            count <= cnt_done ? '0 : count - 1'b1;
        end
    end

    // The flag rises on the edge that enters INT so irq lines up with COUNT reaching 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_flag <= 1'b0;
        end else if (wr_ctrl) begin
            irq_flag <= 1'b0;
        end else if (expire) begin
            irq_flag <= 1'b1;
        end else if (state == S_INT && reload_mode) begin
            irq_flag <= 1'b0;
        end
    end

    assign irq = irq_flag & ctrl_im;

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (offset)
                OFF_CTRL:   rdata[3:0] = {ctrl_im, ctrl_mode, ctrl_en};
                OFF_PRESET: rdata      = preset_ext;
                OFF_COUNT:  rdata      = count_ext;
`ifdef TC_PRESCALE_EN
                OFF_RSVD:   rdata[7:0] = prescale;
`endif
                default:    rdata      = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_tc_timer.sv
// Bench for tc_timer: expected values are queued as stimulus is applied and compared against sampled outputs.
module tb_tc_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    typedef struct {
        string       name;
        logic [31:0] val;
    } item_t;

    item_t       exp_q[$];
    logic [31:0] got_q[$];
    int          n_err;
    int          n_chk;

    tc_timer #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .hit    (hit),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000 ns, want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic cpu_wr(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
        addr   = BASE + {28'd0, off, 2'b00};
        we     = 1'b1;
        wdata  = d;
        byteen = be;
        @(posedge clk);
        #1;
        we     = 1'b0;
        byteen = 4'h0;
    endtask

    task automatic cpu_rd(input logic [1:0] off, output logic [31:0] v);
        addr = BASE + {28'd0, off, 2'b00};
        #1;
        v = rdata;
    endtask

    task automatic test_reset;
        logic [31:0] v;
        item_t e;
        logic [31:0] g;
        reset = 1'b0;
        #1;
        exp_q.push_back('{"reset_irq", 32'd0});   got_q.push_back({31'd0, irq});
        cpu_rd(2'd0, v); exp_q.push_back('{"reset_ctrl", 32'd0});   got_q.push_back(v);
        cpu_rd(2'd1, v); exp_q.push_back('{"reset_preset", 32'd0}); got_q.push_back(v);
        cpu_rd(2'd2, v); exp_q.push_back('{"reset_count", 32'd0});  got_q.push_back(v);
        exp_q.push_back('{"reset_hit", 32'd1});   got_q.push_back({31'd0, hit});
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: got nothing, want 0x%08h", e.name, e.val);
            end else begin
                g = got_q.pop_front();
                if (g !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
                end
            end
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        item_t e;
        logic [31:0] g;
        cpu_wr(2'd1, 32'd5, 4'hF);
        cpu_wr(2'd0, 32'h9, 4'hF);
        for (int k = 1; k <= 9; k++) begin
            step(1);
            exp_q.push_back('{$sformatf("oneshot_irq_k%0d", k), (k >= 7) ? 32'd1 : 32'd0});
            got_q.push_back({31'd0, irq});
            if (k >= 2) begin
                exp_q.push_back('{$sformatf("oneshot_count_k%0d", k), (k >= 7) ? 32'd0 : 32'(7 - k)});
                cpu_rd(2'd2, v);
                got_q.push_back(v);
            end
        end
        cpu_rd(2'd0, v); exp_q.push_back('{"oneshot_en_cleared", 32'h8}); got_q.push_back(v);
        cpu_wr(2'd0, 32'h0, 4'hF);
        exp_q.push_back('{"oneshot_irq_ack", 32'd0}); got_q.push_back({31'd0, irq});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: got nothing, want 0x%08h", e.name, e.val);
            end else begin
                g = got_q.pop_front();
                if (g !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
                end
            end
        end
    endtask

    task automatic test_byteen;
        logic [31:0] v;
        item_t e;
        logic [31:0] g;
        cpu_wr(2'd1, 32'h0, 4'hF);
        cpu_wr(2'd1, 32'hAABB_CCDD, 4'b0010);
        cpu_rd(2'd1, v); exp_q.push_back('{"byteen_preset_b1", 32'h0000_CC00}); got_q.push_back(v);
        cpu_wr(2'd1, 32'h1122_3344, 4'b0001);
        cpu_rd(2'd1, v); exp_q.push_back('{"byteen_preset_b0", 32'h0000_CC44}); got_q.push_back(v);
        cpu_wr(2'd2, 32'hFFFF_FFFF, 4'hF);
        cpu_rd(2'd2, v); exp_q.push_back('{"count_write_ignored", 32'd0}); got_q.push_back(v);
        cpu_wr(2'd0, 32'hFFFF_FF06, 4'hF);
        cpu_rd(2'd0, v); exp_q.push_back('{"ctrl_upper_bits_zero", 32'h6}); got_q.push_back(v);
        cpu_rd(2'd3, v); exp_q.push_back('{"reserved_reads_zero", 32'd0}); got_q.push_back(v);
        cpu_wr(2'd0, 32'h0, 4'hF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: got nothing, want 0x%08h", e.name, e.val);
            end else begin
                g = got_q.pop_front();
                if (g !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
                end
            end
        end
    endtask

    task automatic test_autoreload;
        logic [31:0] v;
        item_t e;
        logic [31:0] g;
        int p;
        cpu_wr(2'd1, 32'd3, 4'hF);
        cpu_wr(2'd0, 32'hB, 4'hF);
        for (int k = 1; k <= 17; k++) begin
            step(1);
            p = (k - 2) % 5;
            exp_q.push_back('{$sformatf("reload_irq_k%0d", k), (k >= 2 && p == 3) ? 32'd1 : 32'd0});
            got_q.push_back({31'd0, irq});
            exp_q.push_back('{$sformatf("reload_count_k%0d", k), (k >= 2 && p < 3) ? 32'(3 - p) : 32'd0});
            cpu_rd(2'd2, v);
            got_q.push_back(v);
        end
        cpu_wr(2'd0, 32'h0, 4'hF);
        step(5);
        exp_q.push_back('{"reload_stop_irq", 32'd0}); got_q.push_back({31'd0, irq});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: got nothing, want 0x%08h", e.name, e.val);
            end else begin
                g = got_q.pop_front();
                if (g !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
                end
            end
        end
    endtask

    task automatic test_preset_zero;
        logic [31:0] v;
        item_t e;
        logic [31:0] g;
        cpu_wr(2'd1, 32'd0, 4'hF);
        cpu_wr(2'd0, 32'h9, 4'hF);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            exp_q.push_back('{$sformatf("pz_irq_k%0d", k), (k >= 3) ? 32'd1 : 32'd0});
            got_q.push_back({31'd0, irq});
        end
        cpu_rd(2'd2, v); exp_q.push_back('{"pz_count", 32'd0}); got_q.push_back(v);
        cpu_rd(2'd0, v); exp_q.push_back('{"pz_en_cleared", 32'h8}); got_q.push_back(v);
        cpu_wr(2'd0, 32'h0, 4'hF);
        exp_q.push_back('{"pz_irq_ack", 32'd0}); got_q.push_back({31'd0, irq});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: got nothing, want 0x%08h", e.name, e.val);
            end else begin
                g = got_q.pop_front();
                if (g !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
                end
            end
        end
    endtask

    task automatic test_im_zero;
        logic [31:0] v;
        item_t e;
        logic [31:0] g;
        logic seen;
        seen = 1'b0;
        cpu_wr(2'd1, 32'd2, 4'hF);
        cpu_wr(2'd0, 32'h1, 4'hF);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            seen = seen | irq;
        end
        exp_q.push_back('{"im0_irq_never", 32'd0}); got_q.push_back({31'd0, seen});
        cpu_rd(2'd0, v); exp_q.push_back('{"im0_en_cleared", 32'd0}); got_q.push_back(v);
        cpu_rd(2'd2, v); exp_q.push_back('{"im0_count", 32'd0}); got_q.push_back(v);
        cpu_wr(2'd0, 32'h8, 4'hF);
        step(2);
        exp_q.push_back('{"im0_late_unmask", 32'd0}); got_q.push_back({31'd0, irq});
        cpu_wr(2'd0, 32'h0, 4'hF);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: got nothing, want 0x%08h", e.name, e.val);
            end else begin
                g = got_q.pop_front();
                if (g !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
                end
            end
        end
    endtask

    task automatic test_nonhit;
        logic [31:0] v;
        item_t e;
        logic [31:0] g;
        addr = 32'h0000_3000;
        #1;
        exp_q.push_back('{"nonhit_hit", 32'd0});   got_q.push_back({31'd0, hit});
        exp_q.push_back('{"nonhit_rdata", 32'd0}); got_q.push_back(rdata);
        addr = 32'h0000_3004; we = 1'b1; wdata = 32'hDEAD_BEEF; byteen = 4'hF;
        @(posedge clk); #1;
        addr = 32'h0000_3000; wdata = 32'h9;
        @(posedge clk); #1;
        we = 1'b0; byteen = 4'h0;
        step(3);
        cpu_rd(2'd1, v); exp_q.push_back('{"nonhit_preset_kept", 32'd2}); got_q.push_back(v);
        cpu_rd(2'd0, v); exp_q.push_back('{"nonhit_ctrl_kept", 32'd0});   got_q.push_back(v);
        exp_q.push_back('{"base_hit", 32'd1}); got_q.push_back({31'd0, hit});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: got nothing, want 0x%08h", e.name, e.val);
            end else begin
                g = got_q.pop_front();
                if (g !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
                end
            end
        end
    endtask

    task automatic test_ctrl_collision;
        logic [31:0] v;
        item_t e;
        logic [31:0] g;
        cpu_wr(2'd1, 32'd1, 4'hF);
        cpu_wr(2'd0, 32'h9, 4'hF);
        step(3);
        exp_q.push_back('{"coll_irq_in_int", 32'd1}); got_q.push_back({31'd0, irq});
        cpu_wr(2'd0, 32'hB, 4'hF);
        exp_q.push_back('{"coll_irq_cleared", 32'd0}); got_q.push_back({31'd0, irq});
        cpu_rd(2'd0, v); exp_q.push_back('{"coll_cpu_wins", 32'hB}); got_q.push_back(v);
        step(2);
        exp_q.push_back('{"coll_irq_t6", 32'd0}); got_q.push_back({31'd0, irq});
        step(1);
        exp_q.push_back('{"coll_irq_t7", 32'd1}); got_q.push_back({31'd0, irq});
        step(1);
        exp_q.push_back('{"coll_irq_t8", 32'd0}); got_q.push_back({31'd0, irq});
        cpu_wr(2'd0, 32'h0, 4'hF);
        step(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: got nothing, want 0x%08h", e.name, e.val);
            end else begin
                g = got_q.pop_front();
                if (g !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
                end
            end
        end
    endtask

    task automatic test_restart;
        logic [31:0] v;
        item_t e;
        logic [31:0] g;
        cpu_wr(2'd1, 32'd6, 4'hF);
        cpu_wr(2'd0, 32'h1, 4'hF);
        step(3);
        cpu_rd(2'd2, v); exp_q.push_back('{"restart_count_t3", 32'd5}); got_q.push_back(v);
        cpu_wr(2'd0, 32'h0, 4'hF);
        step(2);
        cpu_rd(2'd2, v); exp_q.push_back('{"restart_count_held", 32'd4}); got_q.push_back(v);
        cpu_wr(2'd0, 32'h1, 4'hF);
        step(1);
        cpu_rd(2'd2, v); exp_q.push_back('{"restart_count_load", 32'd4}); got_q.push_back(v);
        step(1);
        cpu_rd(2'd2, v); exp_q.push_back('{"restart_full_reload", 32'd6}); got_q.push_back(v);
        step(1);
        cpu_rd(2'd2, v); exp_q.push_back('{"restart_count_next", 32'd5}); got_q.push_back(v);
        cpu_wr(2'd0, 32'h0, 4'hF);
        step(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: got nothing, want 0x%08h", e.name, e.val);
            end else begin
                g = got_q.pop_front();
                if (g !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
                end
            end
        end
    endtask

    task automatic test_reset_midcount;
        logic [31:0] v;
        item_t e;
        logic [31:0] g;
        logic seen;
        seen = 1'b0;
        cpu_wr(2'd1, 32'h20, 4'hF);
        cpu_wr(2'd0, 32'h9, 4'hF);
        step(2);
        cpu_rd(2'd2, v); exp_q.push_back('{"mid_count_loaded", 32'h20}); got_q.push_back(v);
        step(3);
        cpu_rd(2'd2, v); exp_q.push_back('{"mid_count_running", 32'h1D}); got_q.push_back(v);
        #2;
        reset = 1'b0;
        #1;
        exp_q.push_back('{"mid_reset_irq", 32'd0}); got_q.push_back({31'd0, irq});
        cpu_rd(2'd2, v); exp_q.push_back('{"mid_reset_count", 32'd0});  got_q.push_back(v);
        cpu_rd(2'd0, v); exp_q.push_back('{"mid_reset_ctrl", 32'd0});   got_q.push_back(v);
        cpu_rd(2'd1, v); exp_q.push_back('{"mid_reset_preset", 32'd0}); got_q.push_back(v);
        step(2);
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            step(1);
            seen = seen | irq;
        end
        exp_q.push_back('{"post_reset_no_irq", 32'd0}); got_q.push_back({31'd0, seen});
        cpu_rd(2'd2, v); exp_q.push_back('{"post_reset_count", 32'd0}); got_q.push_back(v);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_err++;
                $display("FAIL %s: got nothing, want 0x%08h", e.name, e.val);
            end else begin
                g = got_q.pop_front();
                if (g !== e.val) begin
                    n_err++;
                    $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, g, e.val);
                end
            end
        end
    endtask

    initial begin
        n_err  = 0;
        n_chk  = 0;
        reset  = 1'b0;
        addr   = BASE;
        we     = 1'b0;
        byteen = 4'h0;
        wdata  = 32'h0;
        test_reset();
        test_oneshot();
        test_byteen();
        test_autoreload();
        test_preset_zero();
        test_im_zero();
        test_nonhit();
        test_ctrl_collision();
        test_restart();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
